m_serialshift: RTL

M_SERIALSHIFT -- requirements
Module: m_serialshift

---
 rtl/m_serialshift_pkg.sv | 32 +++
 rtl/m_serialshift_cnt.sv | 34 +++
 rtl/m_serialshift.sv | 121 ++++++++++++
 3 files changed

// File: rtl/m_serialshift_pkg.sv
// Shared constants for the serial shifter: op encodings, shift-amount width,
// FSM state type and the single-step shift function.
package m_serialshift_pkg;

   localparam int SHW = 5;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b11;

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   // One shift step of 1 or 4 bits; the reserved op code falls through to SRL.
   function automatic logic [31:0] shift_step(
      input logic [31:0] v,
      input logic [1:0]  op,
      input logic        fill,
      input logic        by4
   );
      logic [31:0] r;
      case (op)
         OP_SLL:  r = by4 ? {v[27:0], 4'b0000}     : {v[30:0], 1'b0};
         OP_SRA:  r = by4 ? {{4{fill}}, v[31:4]}   : {fill, v[31:1]};
         default: r = by4 ? {4'b0000, v[31:4]}     : {1'b0, v[31:1]};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/m_serialshift_cnt.sv
// Shift-amount down counter: load, decrement by 1 or 4, never wraps below zero.
module m_serialshift_cnt
   import m_serialshift_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           i_load,
   input  logic [SHW-1:0] i_ld_val,
   input  logic           i_dec,
   input  logic           i_dec4,
   output logic [SHW-1:0] o_cnt,
   output logic           o_is_one,
   output logic           o_is_zero
);

   logic [SHW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_ld_val;
      end else if (i_dec4 && (r_cnt >= SHW'(4))) begin
         r_cnt <= r_cnt - SHW'(4);
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - SHW'(1);
      end
   end

   assign o_cnt     = r_cnt;
   assign o_is_one  = (r_cnt == SHW'(1));
   assign o_is_zero = (r_cnt == '0);

endmodule

// File: rtl/m_serialshift.sv
// Multi-cycle serial shifter (SLL/SRL/SRA), one bit per clock, or four bits per
// clock while at least four remain when MIDGETV_SHIFT4_EN is defined.
module m_serialshift
   import m_serialshift_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [31:0]    A,
   input  logic [SHW-1:0] shamt,
   output logic           busy,
   output logic           done,
   output logic [31:0]    result,
   output logic           lastshift
);

   state_t         r_state;
   state_t         w_state_next;
   logic           r_busy;
   logic           r_done;
   logic [31:0]    r_result;
   logic [1:0]     r_op;
   logic           r_fill;

   logic           w_load;
   logic           w_dec;
   logic           w_dec4;
   logic           w_fin;
   logic [SHW-1:0] w_cnt;
   logic           w_is_one;
   logic           w_is_zero;
   logic [31:0]    w_shifted;

   m_serialshift_cnt u_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_ld_val  (shamt),
      .i_dec     (w_dec),
      .i_dec4    (w_dec4),
      .o_cnt     (w_cnt),
      .o_is_one  (w_is_one),
      .o_is_zero (w_is_zero)
   );

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_dec        = 1'b0;
      w_dec4       = 1'b0;
      w_fin        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load       = 1'b1;
               w_state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // Start is deliberately not looked at here: no reload while shifting.
            if (w_is_zero) begin
               w_fin = 1'b1;
`ifdef MIDGETV_SHIFT4_EN
            end else if (w_cnt >= SHW'(4)) begin
               w_dec4 = 1'b1;
               w_fin  = (w_cnt == SHW'(4));
`endif
            end else begin
               w_dec = 1'b1;
               w_fin = w_is_one;
            end
            if (w_fin) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_shifted = shift_step(r_result, r_op, r_fill, w_dec4);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_op     <= OP_SLL;
         r_fill   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= w_fin;
         if (w_load) begin
            r_result <= A;
            r_op     <= op;
            r_fill   <= A[31];
            // A zero shift completes on the next edge without ever reporting busy.
            r_busy   <= (shamt != '0);
         end else begin
            if (w_dec || w_dec4) begin
               r_result <= w_shifted;
            end
            if (w_fin) begin
               r_busy <= 1'b0;
            end
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

`ifdef MIDGETV_SHIFT4_EN
   assign lastshift = r_busy & (w_is_one | (w_cnt == SHW'(4)));
`else
   assign lastshift = r_busy & w_is_one;
`endif

endmodule
